// File: rtl/cpp_internal_int_to_clocked_level.sv
`default_nettype none
// ============================================================================
// Module   : cpp_internal_int_to_clocked_level
// Purpose  : Brings the 32-bit int output of the double-to-int threshold
//            converter, together with its toggle-per-sample update line, into
//            the clk domain. Debounces the 0/1 decision (in != 0) over
//            DEBOUNCE clocks. Produces a clean level, single-cycle rise/fall/
//            glitch strobes and a saturating transition counter.
// Ports    : clk        - sampling clock, all state on rising edge
//            rst_n      - asynchronous active-low reset
//            in         - int from converter, decision bit = (in != 0)
//            update_in  - update event line, every value change = new sample
//            clear_cnt  - synchronous clear of edge_count
//            level      - debounced level
//            rise       - one-cycle pulse after a 0->1 flip of level
//            fall       - one-cycle pulse after a 1->0 flip of level
//            glitch     - one-cycle pulse when a pending change is abandoned
//            edge_count - saturating count of level transitions
// Revision : 1.0 - initial release
// ============================================================================
module cpp_internal_int_to_clocked_level #(
  parameter int SYNC_STAGES = 2,   // legal 2..4
  parameter int DEBOUNCE    = 4,   // legal 1..255
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in,
  input  logic             update_in,
  input  logic             clear_cnt,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [CNT_W-1:0] edge_count
);

  // Debounce counter never needs more than 8 bits: it tops out at DEBOUNCE-1
  // and the compare value cnt+1 is at most 255.
  localparam logic [7:0]       c_DEBOUNCE = 8'(DEBOUNCE);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic                   w_raw;
  logic [SYNC_STAGES-1:0] raw_sync_q;
  logic [SYNC_STAGES-1:0] upd_sync_q;
  logic                   w_raw_s;
  logic                   w_upd_s;

  assign w_raw = (in != 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_sync_q <= '0;
      upd_sync_q <= '0;
    end else begin
      raw_sync_q <= {raw_sync_q[SYNC_STAGES-2:0], w_raw};
      upd_sync_q <= {upd_sync_q[SYNC_STAGES-2:0], update_in};
    end
  end

  assign w_raw_s = raw_sync_q[SYNC_STAGES-1];
  assign w_upd_s = upd_sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Update detection and candidate capture
  // --------------------------------------------------------------------------
  // The update line is a toggle, not a pulse: any difference between the
  // synchronised value and its one-clock-old copy marks a fresh sample. Both
  // synchronisers have the same depth, so raw_s is aligned with that toggle.
  logic upd_prev_q;
  logic w_upd_pulse;
  logic cand_q;
  logic cand_d;

  assign w_upd_pulse = w_upd_s ^ upd_prev_q;
  assign cand_d      = w_upd_pulse ? w_raw_s : cand_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_prev_q <= 1'b0;
      cand_q     <= 1'b0;
    end else begin
      upd_prev_q <= w_upd_s;
      cand_q     <= cand_d;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [7:0]       w_cnt_inc;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  logic             glitch_q;
  logic             glitch_d;
  logic             w_flip;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [CNT_W-1:0] edge_cnt_d;

  assign w_cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STABLE;
      cnt_q      <= 8'd0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      glitch_q   <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      glitch_q   <= glitch_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;
    w_flip   = 1'b0;

    unique case (state_q)
      ST_STABLE: begin
        if (cand_q != level_q) begin
          // With a one-clock debounce there is nothing to wait for.
          if (DEBOUNCE == 1) begin
            w_flip = 1'b1;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = 8'd1;
          end
        end
      end

      ST_PENDING: begin
        if (cand_q != level_q) begin
          if (w_cnt_inc == c_DEBOUNCE) begin
            w_flip  = 1'b1;
            cnt_d   = 8'd0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end else begin
          // Candidate fell back to the current level before the debounce
          // window completed: drop the pending change and report it.
          state_d  = ST_STABLE;
          cnt_d    = 8'd0;
          glitch_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_STABLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Level and strobe generation; a flip and a glitch are mutually exclusive
  // because they come from different FSM branches.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (w_flip) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      fall_d  = level_q;
    end
  end

  // --------------------------------------------------------------------------
  // Transition counter
  // --------------------------------------------------------------------------
  // A clear that coincides with a flip keeps that flip, so the count restarts
  // at one rather than zero.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (w_flip) begin
      if (clear_cnt) begin
        edge_cnt_d = c_CNT_ONE;
      end else if (!(&edge_cnt_q)) begin
        edge_cnt_d = edge_cnt_q + c_CNT_ONE;
      end
    end else if (clear_cnt) begin
      edge_cnt_d = '0;
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch     = glitch_q;
  assign edge_count = edge_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpp_internal_int_to_clocked_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpp_internal_int_to_clocked_level
// Purpose  : Directed bench for cpp_internal_int_to_clocked_level. Three
//            instances share clock and reset: defaults, CNT_W=2 for counter
//            saturation, DEBOUNCE=1 for the immediate-flip path.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpp_internal_int_to_clocked_level;

  logic        clk;
  logic        rst_n;

  // default instance
  logic [31:0] in_m;
  logic        upd_m;
  logic        clr_m;
  logic        level_m, rise_m, fall_m, glitch_m;
  logic [15:0] cnt_m;

  // CNT_W = 2 instance
  logic [31:0] in_s;
  logic        upd_s;
  logic        clr_s;
  logic        level_s, rise_s, fall_s, glitch_s;
  logic [1:0]  cnt_s;

  // DEBOUNCE = 1 instance
  logic [31:0] in_1;
  logic        upd_1;
  logic        clr_1;
  logic        level_1, rise_1, fall_1, glitch_1;
  logic [15:0] cnt_1;

  int n_assert = 0;
  int n_fail   = 0;

  cpp_internal_int_to_clocked_level dut (
    .clk(clk), .rst_n(rst_n), .in(in_m), .update_in(upd_m), .clear_cnt(clr_m),
    .level(level_m), .rise(rise_m), .fall(fall_m), .glitch(glitch_m),
    .edge_count(cnt_m)
  );

  cpp_internal_int_to_clocked_level #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in(in_s), .update_in(upd_s), .clear_cnt(clr_s),
    .level(level_s), .rise(rise_s), .fall(fall_s), .glitch(glitch_s),
    .edge_count(cnt_s)
  );

  cpp_internal_int_to_clocked_level #(.DEBOUNCE(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in(in_1), .update_in(upd_1), .clear_cnt(clr_1),
    .level(level_1), .rise(rise_1), .fall(fall_1), .glitch(glitch_1),
    .edge_count(cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_sat [5];

  initial begin
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;

    rst_n = 1'b0;
    in_m = 32'd1; upd_m = 1'b0; clr_m = 1'b0;
    in_s = 32'd0; upd_s = 1'b0; clr_s = 1'b0;
    in_1 = 32'd0; upd_1 = 1'b0; clr_1 = 1'b0;

    // ---- Reset held for 3 cycles while update_in toggles ----
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      upd_m = ~upd_m;
    end
    chk("rst_level",  level_m,  0);
    chk("rst_rise",   rise_m,   0);
    chk("rst_fall",   fall_m,   0);
    chk("rst_glitch", glitch_m, 0);
    chk("rst_count",  cnt_m,    0);

    // ---- Release with in=1, update_in=1: flip at edge 7 ----
    rst_n = 1'b1;
    cycles(6);
    chk("nom_level_e6", level_m, 0);
    chk("nom_rise_e6",  rise_m,  0);
    cycles(1);
    chk("nom_level_e7", level_m,  1);
    chk("nom_rise_e7",  rise_m,   1);
    chk("nom_fall_e7",  fall_m,   0);
    chk("nom_glit_e7",  glitch_m, 0);
    chk("nom_cnt_e7",   cnt_m,    1);
    cycles(1);
    chk("nom_rise_e8",  rise_m,  0);
    chk("nom_level_e8", level_m, 1);

    // ---- Falling transition ----
    in_m = 32'd0; upd_m = ~upd_m;
    cycles(6);
    chk("fall_level_e6", level_m, 1);
    cycles(1);
    chk("fall_level_e7", level_m, 0);
    chk("fall_fall_e7",  fall_m,  1);
    chk("fall_rise_e7",  rise_m,  0);
    chk("fall_cnt_e7",   cnt_m,   2);
    cycles(1);
    chk("fall_fall_e8",  fall_m,  0);

    // ---- Change of in without update is ignored ----
    in_m = 32'd5;
    cycles(20);
    chk("ign_level", level_m,  0);
    chk("ign_cnt",   cnt_m,    2);
    chk("ign_glit",  glitch_m, 0);

    // ---- Glitch: candidate goes 1 then back to 0 two clocks later ----
    in_m = 32'd1; upd_m = ~upd_m;
    cycles(2);
    in_m = 32'd0; upd_m = ~upd_m;
    cycles(3);
    chk("gl_glit_e5", glitch_m, 0);
    cycles(1);
    chk("gl_glit_e6",  glitch_m, 1);
    chk("gl_level_e6", level_m,  0);
    chk("gl_rise_e6",  rise_m,   0);
    chk("gl_fall_e6",  fall_m,   0);
    cycles(1);
    chk("gl_glit_e7", glitch_m, 0);
    cycles(10);
    chk("gl_level_late", level_m, 0);
    chk("gl_cnt_late",   cnt_m,   2);

    // ---- Clear on a non-flip edge ----
    clr_m = 1'b1;
    cycles(1);
    clr_m = 1'b0;
    chk("clr_cnt", cnt_m, 0);

    // ---- Reset in the middle of a pending change ----
    in_m = 32'd1; upd_m = ~upd_m;
    cycles(5);
    chk("mid_level_e5", level_m, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_level_async", level_m, 0);
    chk("mid_rise_async",  rise_m,  0);
    in_m = 32'd0;
    cycles(2);
    rst_n = 1'b1;
    cycles(10);
    chk("mid_level_after", level_m, 0);
    chk("mid_rise_after",  rise_m,  0);
    chk("mid_cnt_after",   cnt_m,   0);

    // ---- Saturation with CNT_W=2 ----
    for (int k = 0; k < 5; k++) begin
      in_s  = (k % 2 == 0) ? 32'd1 : 32'd0;
      upd_s = ~upd_s;
      cycles(8);
      chk("sat_cnt", cnt_s, exp_sat[k]);
    end
    chk("sat_level", level_s, 1);
    // sixth transition, clear coincident with the flip edge (edge 7)
    in_s  = 32'd0;
    upd_s = ~upd_s;
    cycles(6);
    chk("satclr_cnt_e6", cnt_s, 3);
    clr_s = 1'b1;
    cycles(1);
    clr_s = 1'b0;
    chk("satclr_cnt_e7",  cnt_s,   1);
    chk("satclr_level",   level_s, 0);
    chk("satclr_fall",    fall_s,  1);

    // ---- DEBOUNCE=1: flip at edge SYNC_STAGES+2 = 4 ----
    in_1  = 32'd1;
    upd_1 = ~upd_1;
    cycles(3);
    chk("d1_level_e3", level_1, 0);
    cycles(1);
    chk("d1_level_e4", level_1, 1);
    chk("d1_rise_e4",  rise_1,  1);
    chk("d1_cnt_e4",   cnt_1,   1);
    cycles(1);
    chk("d1_rise_e5",  rise_1,   0);
    chk("d1_glit_e5",  glitch_1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpp_internal_int_to_clocked_level.md
Name: cpp_internal_int_to_clocked_level

Overview:
- Downstream consumer of the double-to-int threshold converter.
- Takes its 32-bit int output and its update event line (toggle-per-sample), and resynchronises both into a clocked digital domain.
- Debounces the resulting 0/1 decision over a programmable number of clocks.
- Produces a clean level, single-cycle rise/fall/glitch strobes and a saturating edge counter for clocked RTL under co-simulation.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser chain (legal 2..4).
- DEBOUNCE, 4, consecutive clock edges the candidate must differ from level before level flips (legal 1..255).
- CNT_W, 16, width of edge_count.

Ports:
- clk  input  1  sampling clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  32  int from converter; decision bit raw = (in != 0).
- update_in  input  1  update event line; each change of value marks a new sample.
- clear_cnt  input  1  synchronous clear of edge_count.
- level  output  1  debounced level.
- rise  output  1  one-cycle pulse when level goes 0->1.
- fall  output  1  one-cycle pulse when level goes 1->0.
- glitch  output  1  one-cycle pulse when a pending change is abandoned.
- edge_count  output  CNT_W  count of level transitions, saturating.

Behaviour:
- Reset (rst_n low, async): all sync flops, upd_d, cand, level, rise, fall, glitch, edge_count = 0; FSM = STABLE; cnt = 0. Release takes effect at the next clk edge.
- Synchronisers: raw and update_in each pass through SYNC_STAGES flops to give raw_s and upd_s.
- Update detect: upd_pulse = upd_s XOR upd_d (combinational); upd_d <= upd_s every edge.
- Candidate: on an edge with upd_pulse=1, cand <= raw_s; otherwise cand holds.
- A change of in without a change of update_in is never sampled.
- FSM, two states, evaluated on the registered cand:
  - STABLE, cand == level: stay.
  - STABLE, cand != level, DEBOUNCE == 1: flip level immediately, stay STABLE.
  - STABLE, cand != level, DEBOUNCE > 1: go to PENDING, cnt <= 1.
  - PENDING, cand != level: cnt <= cnt+1. When cnt+1 == DEBOUNCE, flip level, cnt <= 0, go to STABLE.
  - PENDING, cand == level: go to STABLE, cnt <= 0, pulse glitch; level unchanged.
- Flip: level <= ~level on the flip edge. rise (new level 1) or fall (new level 0) is registered high for exactly the cycle following that edge. rise, fall and glitch are never asserted together.
- Latency: if in and update_in change before edge 1, level flips at edge SYNC_STAGES+DEBOUNCE+1 (defaults: edge 7). Strobes are high in cycle 7..8.
- edge_count:
  - Increments by 1 on each flip edge; saturates at 2^CNT_W-1 (no wrap).
  - clear_cnt high on a non-flip edge: count <= 0.
  - clear_cnt high on a flip edge: count <= 1.
- A new update arriving while PENDING only changes cand. Debounce continues or aborts per the rules above, based on the new cand.
- Back-to-back updates faster than one per clock collapse: only the upd_s value at each edge is seen, and an even number of toggles between edges is lost. This is acceptable and is not flagged.
- Reset mid-PENDING: state discarded, no strobe, level = 0.

Test Plan:
- Reset: rst_n low for 3 cycles with in=1 and update_in toggling -> level=0, all strobes 0, edge_count=0; release, hold inputs -> first rise pulse at edge 7 after the first sampled toggle.
- Nominal rising edge: defaults, in=1 and update_in 0->1 before edge 1 -> level=1 at edge 7; rise high for one cycle; edge_count=1; fall=glitch=0.
- Glitch: in=1 with toggle, then in=0 with toggle two clocks later (cand reverts at edge 5) -> glitch pulse, level stays 0, edge_count=0.
- Ignored change: in goes 0->5 with no update_in change for 20 cycles -> level, cand and edge_count unchanged.
- Saturation and clear: CNT_W=2, drive 5 full transitions -> edge_count sticks at 3; clear_cnt coincident with the 6th flip edge -> edge_count=1.
- DEBOUNCE=1: toggle with in=1 -> level=1 at edge SYNC_STAGES+2 (edge 4); mid-PENDING async reset with DEBOUNCE=4 -> immediate level=0, no rise.
